// File: rtl/sha2_padder.sv
// FIPS 180-4 message padder: packs a byte stream into 64/128-byte blocks, appends 0x80,
// zero fill and the big-endian bit length, and emits 512-bit beats toward the W(t) unit.
module sha2_padder #(
    parameter int S_AXIS_DATA_WIDTH = 64,
    parameter int M_AXIS_DATA_WIDTH = 512,
    parameter int LEN_CNT_WIDTH     = 64
) (
    input  logic                           axi_aclk,
    input  logic                           reset,
    input  logic [1:0]                     sha_type,
    input  logic                           en,
    input  logic [S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam int LANES       = S_AXIS_DATA_WIDTH / 8;
    localparam int HALF_BYTES  = M_AXIS_DATA_WIDTH / 8;
    localparam int MAX_BLK     = 2 * HALF_BYTES;
    localparam int BLK_W       = 2 * M_AXIS_DATA_WIDTH;
    localparam int PTR_W       = $clog2(MAX_BLK + LANES + 1);
    localparam int KEEP_CNT_W  = $clog2(LANES + 1);
    localparam int LEN_FIELD_W = 128;
    localparam int LEN_NARROW  = 8;
    localparam int LEN_WIDE    = LEN_FIELD_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        LEN,
        EMIT
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [BLK_W-1:0]         blk_q;
    logic [BLK_W-1:0]         blk_next;
    logic [PTR_W-1:0]         ptr;
    logic [LEN_CNT_WIDTH-1:0] cnt;
    logic [1:0]               type_q;
    logic                     pend_pad;
    logic                     need_len;
    logic                     last_msg;
    logic                     beat_sel;

    logic                     wide;
    logic                     s_hs;
    logic                     m_hs;
    logic [KEEP_CNT_W-1:0]    keep_cnt;
    logic [PTR_W-1:0]         ptr_sum;
    logic [PTR_W-1:0]         blk_bytes;
    logic [PTR_W-1:0]         len_bytes;
    logic                     blk_full;
    logic                     len_fits;
    logic                     final_beat;
    int                       wr_idx;

    function automatic logic [KEEP_CNT_W-1:0] popcount(input logic [LANES-1:0] keep);
        logic [KEEP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + KEEP_CNT_W'(keep[i]);
        end
        return n;
    endfunction

    // Length field occupies the last 8 or 16 bytes; bits above cnt*8 stay zero.
    function automatic logic [BLK_W-1:0] write_len(input logic [BLK_W-1:0] blk,
                                                   input logic [LEN_CNT_WIDTH-1:0] count,
                                                   input logic is_wide);
        logic [BLK_W-1:0]       res;
        logic [LEN_FIELD_W-1:0] field;
        int                     top;
        res   = blk;
        field = '0;
        field[LEN_CNT_WIDTH+2:0] = {count, 3'b000};
        top   = is_wide ? MAX_BLK - 1 : HALF_BYTES - 1;
        for (int k = 0; k < LEN_WIDE; k++) begin
            if (is_wide || k < LEN_NARROW) begin
                res[(top - k) * 8 +: 8] = field[k * 8 +: 8];
            end
        end
        return res;
    endfunction

    assign wide       = type_q inside {2'b10, 2'b11};
    assign s_hs       = s_axis_tready && s_axis_tvalid;
    assign m_hs       = m_axis_tvalid && m_axis_tready;
    assign keep_cnt   = popcount(s_axis_tkeep);
    assign ptr_sum    = ptr + PTR_W'(keep_cnt);
    assign blk_bytes  = wide ? PTR_W'(MAX_BLK) : PTR_W'(HALF_BYTES);
    assign len_bytes  = wide ? PTR_W'(LEN_WIDE) : PTR_W'(LEN_NARROW);
    assign blk_full   = ptr_sum >= blk_bytes;
    assign len_fits   = (ptr + PTR_W'(1)) <= (blk_bytes - len_bytes);
    assign final_beat = !wide || beat_sel;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (s_hs) begin
                    if (blk_full) begin
                        state_next = EMIT;
                    end else if (s_axis_tlast) begin
                        state_next = PAD;
                    end
                end
            end
            PAD:     state_next = EMIT;
            LEN:     state_next = EMIT;
            EMIT: begin
                if (m_hs && final_beat) begin
                    if (pend_pad) begin
                        state_next = PAD;
                    end else if (need_len) begin
                        state_next = LEN;
                    end else if (last_msg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (state == FILL);
        m_axis_tvalid = (state == EMIT);
        m_axis_tlast  = (state == EMIT) && last_msg;
        // Wide blocks go out upper half first.
        if (wide && !beat_sel) begin
            m_axis_tdata = blk_q[BLK_W-1:M_AXIS_DATA_WIDTH];
        end else begin
            m_axis_tdata = blk_q[M_AXIS_DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        blk_next = blk_q;
        wr_idx   = int'(ptr);
        case (state)
            FILL: begin
                if (s_hs) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (s_axis_tkeep[i]) begin
                            if (wr_idx < int'(blk_bytes)) begin
                                blk_next[wr_idx * 8 +: 8] = s_axis_tdata[i * 8 +: 8];
                            end
                            wr_idx = wr_idx + 1;
                        end
                    end
                end
            end
            PAD: begin
                if (ptr < blk_bytes) begin
                    blk_next[wr_idx * 8 +: 8] = 8'h80;
                end
                if (len_fits) begin
                    blk_next = write_len(blk_next, cnt, wide);
                end
            end
            LEN: begin
                blk_next = write_len(blk_next, cnt, wide);
            end
            EMIT: begin
                if (m_hs && final_beat) begin
                    blk_next = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            blk_q    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            type_q   <= '0;
            pend_pad <= 1'b0;
            need_len <= 1'b0;
            last_msg <= 1'b0;
            beat_sel <= 1'b0;
        end else begin
            blk_q <= blk_next;
            case (state)
                IDLE: begin
                    if (en) begin
                        type_q   <= sha_type;
                        ptr      <= '0;
                        cnt      <= '0;
                        pend_pad <= 1'b0;
                        need_len <= 1'b0;
                        last_msg <= 1'b0;
                        beat_sel <= 1'b0;
                    end
                end
                FILL: begin
                    if (s_hs) begin
                        ptr <= ptr_sum;
                        cnt <= cnt + LEN_CNT_WIDTH'(keep_cnt);
                        // A message ending exactly on a block boundary pads into a fresh block.
                        if (blk_full && s_axis_tlast) begin
                            pend_pad <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    pend_pad <= 1'b0;
                    if (len_fits) begin
                        last_msg <= 1'b1;
                    end else begin
                        need_len <= 1'b1;
                    end
                end
                LEN: begin
                    need_len <= 1'b0;
                    last_msg <= 1'b1;
                end
                EMIT: begin
                    if (m_hs) begin
                        if (final_beat) begin
                            beat_sel <= 1'b0;
                            ptr      <= '0;
                        end else begin
                            beat_sel <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_padder.sv
// Scoreboard bench for sha2_padder: random messages are padded by a byte-queue reference
// model, expected beats are queued, and an independent monitor checks every output beat.
module tb_sha2_padder;

    localparam int TMO = 2000;

    logic         axi_aclk = 1'b0;
    logic         reset;
    logic [1:0]   sha_type;
    logic         en;
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] msg_q[$];
    int         errors = 0;
    int         checks = 0;
    int         ready_mode = 0;

    always #5 axi_aclk = ~axi_aclk;

    sha2_padder dut (
        .axi_aclk      (axi_aclk),
        .reset         (reset),
        .sha_type      (sha_type),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: append 0x80, zero-fill to BLK-LB mod BLK, append big-endian bit length.
    task automatic build_expected(input logic [1:0] typ);
        logic [7:0]   p[$];
        logic [127:0] lenbits;
        beat_t        b;
        int           blk, lb, nblk, base;
        blk = typ[1] ? 128 : 64;
        lb  = typ[1] ? 16 : 8;
        p   = msg_q;
        p.push_back(8'h80);
        while ((p.size() % blk) != (blk - lb)) p.push_back(8'h00);
        lenbits = 128'(msg_q.size()) * 128'd8;
        for (int k = lb - 1; k >= 0; k--) p.push_back(lenbits[k*8 +: 8]);
        nblk = p.size() / blk;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int h = 0; h < blk / 64; h++) begin
                base = bi * blk + ((blk == 128 && h == 0) ? 64 : 0);
                for (int k = 0; k < 64; k++) b.data[k*8 +: 8] = p[base + k];
                b.last = (bi == nblk - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int w;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        w = 0;
        while (!s_axis_tready && w < TMO) begin
            @(negedge axi_aclk);
            w++;
        end
        if (w >= TMO) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: ready=0 after %0d cycles, required 1", w);
        end
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Called on a negedge; sends msg_q, optionally stopping before tlast (abort).
    task automatic send_msg(input logic [1:0] typ, input bit abort);
        int         n, nbeats, w, lat, blk;
        logic [63:0] d;
        logic [7:0]  k;
        n   = msg_q.size();
        blk = typ[1] ? 128 : 64;
        sha_type = typ;
        en = 1'b1;
        w = 0;
        while (!s_axis_tready && w < TMO) begin
            @(negedge axi_aclk);
            w++;
        end
        en = 1'b0;
        if (w >= TMO) begin
            checks++;
            errors++;
            $display("FAIL start: ready=0 after %0d cycles, required 1", w);
        end
        sha_type = 2'($urandom);
        nbeats = (n == 0) ? 1 : (n + 7) / 8;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge axi_aclk);
            d = {$urandom, $urandom};
            k = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (i * 8 + j < n) begin
                    d[j*8 +: 8] = msg_q[i*8 + j];
                    k[j] = 1'b1;
                end
            end
            drive_beat(d, k, !abort && (i == nbeats - 1));
        end
        if (!abort && (n == 0 || (n % blk) != 0)) begin
            lat = 1;
            while (!m_axis_tvalid && lat < 10) begin
                @(negedge axi_aclk);
                lat++;
            end
            check("latency", 512'(lat), 512'd2);
        end
    endtask

    task automatic run_msg(input logic [1:0] typ, input int n, input bit abc);
        msg_q.delete();
        if (abc) begin
            msg_q.push_back(8'h61);
            msg_q.push_back(8'h62);
            msg_q.push_back(8'h63);
        end else begin
            for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
        end
        build_expected(typ);
        send_msg(typ, 1'b0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge axi_aclk);
            w++;
        end
        check("drain", 512'(exp_q.size()), 512'd0);
    endtask

    initial begin : ready_drv
        int ph;
        ph = 0;
        m_axis_tready = 1'b0;
        forever begin
            @(posedge axi_aclk);
            #1;
            case (ready_mode)
                0: m_axis_tready = 1'b1;
                1: begin
                    ph = (ph + 1) % 3;
                    m_axis_tready = (ph == 0);
                end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic         stall_prev;
        logic [511:0] data_prev;
        beat_t        e;
        stall_prev = 1'b0;
        data_prev  = '0;
        forever begin
            @(negedge axi_aclk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!m_axis_tvalid || m_axis_tdata !== data_prev) begin
                        errors++;
                        $display("FAIL hold: valid=%0b data_changed=%0b required valid=1 unchanged",
                                 m_axis_tvalid, m_axis_tdata !== data_prev);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got beat tlast=%0b, required no beat", m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                            errors++;
                            $display("FAIL beat: tdata=%h tlast=%0b required tdata=%h tlast=%0b",
                                     m_axis_tdata, m_axis_tlast, e.data, e.last);
                        end
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                data_prev  = m_axis_tdata;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        en = 1'b0;
        sha_type = 2'b00;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) @(negedge axi_aclk);
        check("rst_s_tready", 512'(s_axis_tready), 512'd0);
        check("rst_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("rst_m_tlast", 512'(m_axis_tlast), 512'd0);
        check("rst_m_tdata", m_axis_tdata, 512'd0);
        reset = 1'b0;
        @(negedge axi_aclk);

        ready_mode = 0;
        run_msg(2'b00, 3, 1'b1);
        run_msg(2'b01, 0, 1'b0);
        run_msg(2'b00, 56, 1'b0);
        run_msg(2'b01, 64, 1'b0);
        run_msg(2'b10, 3, 1'b1);
        run_msg(2'b11, 0, 1'b0);

        ready_mode = 1;
        run_msg(2'b11, 112, 1'b0);
        run_msg(2'b10, 128, 1'b0);
        run_msg(2'b00, 55, 1'b0);
        run_msg(2'b11, 200, 1'b0);

        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            run_msg(2'($urandom), int'($urandom_range(0, 300)), 1'b0);
        end
        drain();

        // Reset in the middle of filling a block, with the sink toggling 1-in-3.
        ready_mode = 1;
        msg_q.delete();
        for (int i = 0; i < 24; i++) msg_q.push_back(8'($urandom));
        send_msg(2'b00, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge axi_aclk);
        check("midrst_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("midrst_m_tdata", m_axis_tdata, 512'd0);
        reset = 1'b0;
        repeat (3) @(negedge axi_aclk);
        check("post_rst_s_tready", 512'(s_axis_tready), 512'd0);
        check("post_rst_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check("post_rst_m_tlast", 512'(m_axis_tlast), 512'd0);

        run_msg(2'b00, 3, 1'b1);
        run_msg(2'b11, 130, 1'b0);
        drain();
        repeat (5) @(negedge axi_aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
